// File: rtl/wb_writeback_unit.sv
// Writeback stage: accepts retiring instructions from MEM, waits for load
// data, formats it, and issues one registered register-file write per
// retirement while counting retired instructions.
module wb_writeback_unit #(
  parameter int INSTRET_W = 64,
  parameter int XLEN      = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic                 mem_reg_write,
  input  logic [4:0]           mem_rd,
  input  logic                 mem_is_load,
  input  logic [2:0]           mem_funct3,
  input  logic [1:0]           mem_addr_lo,
  input  logic [XLEN-1:0]      mem_result,
  input  logic                 dmem_rvalid,
  input  logic [XLEN-1:0]      dmem_rdata,
  output logic                 wEn,
  output logic [4:0]           write_sel,
  output logic [XLEN-1:0]      write_data,
  output logic [INSTRET_W-1:0] instret,
  output logic                 wb_err
);

  typedef enum logic {IDLE = 1'b0, WAIT_LOAD = 1'b1} state_e;

  state_e                state_q, state_d;
  logic                  wen_q, wen_d;
  logic [4:0]            sel_q, sel_d;
  logic [XLEN-1:0]       data_q, data_d;
  logic [INSTRET_W-1:0]  instret_q, instret_d;
  logic                  err_q, err_d;
  // Load context captured at acceptance, used when the read data returns
  logic [4:0]            ld_rd_q, ld_rd_d;
  logic                  ld_rw_q, ld_rw_d;
  logic [2:0]            ld_f3_q, ld_f3_d;
  logic [1:0]            ld_lo_q, ld_lo_d;

  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [XLEN-1:0]       ld_data;
  logic                  ld_err;

  localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

  assign mem_ready  = (state_q == IDLE);
  assign wEn        = wen_q;
  assign write_sel  = sel_q;
  assign write_data = data_q;
  assign instret    = instret_q;
  assign wb_err     = err_q;

  // Align and extend the returning load word using the captured context
  always_comb begin
    ld_byte = dmem_rdata[{ld_lo_q, 3'b000} +: 8];
    ld_half = dmem_rdata[{ld_lo_q[1], 4'b0000} +: 16];
    ld_data = '0;
    ld_err  = 1'b0;
    case (ld_f3_q)
      3'b000: ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100: ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001: begin
        ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
        ld_err  = ld_lo_q[0];
      end
      3'b101: begin
        ld_data = {{(XLEN-16){1'b0}}, ld_half};
        ld_err  = ld_lo_q[0];
      end
      3'b010:  ld_data = dmem_rdata;
      default: ld_err  = 1'b1;
    endcase
  end

  // Next-state: accept in IDLE, retire non-loads at once, loads on rvalid
  always_comb begin
    state_d   = state_q;
    wen_d     = 1'b0;
    sel_d     = sel_q;
    data_d    = data_q;
    instret_d = instret_q;
    err_d     = err_q;
    ld_rd_d   = ld_rd_q;
    ld_rw_d   = ld_rw_q;
    ld_f3_d   = ld_f3_q;
    ld_lo_d   = ld_lo_q;
    case (state_q)
      IDLE: begin
        // Read data with no outstanding load is a protocol error
        if (dmem_rvalid) err_d = 1'b1;
        if (mem_valid) begin
          if (mem_is_load) begin
            ld_rd_d = mem_rd;
            ld_rw_d = mem_reg_write;
            ld_f3_d = mem_funct3;
            ld_lo_d = mem_addr_lo;
            state_d = WAIT_LOAD;
          end else begin
            wen_d     = mem_reg_write & (mem_rd != 5'd0);
            sel_d     = mem_rd;
            data_d    = mem_result;
            instret_d = instret_q + INSTRET_ONE;
          end
        end
      end
      WAIT_LOAD: begin
        if (dmem_rvalid) begin
          wen_d     = ld_rw_q & (ld_rd_q != 5'd0);
          sel_d     = ld_rd_q;
          data_d    = ld_data;
          instret_d = instret_q + INSTRET_ONE;
          if (ld_err) err_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      wen_q     <= 1'b0;
      sel_q     <= '0;
      data_q    <= '0;
      instret_q <= '0;
      err_q     <= 1'b0;
      ld_rd_q   <= '0;
      ld_rw_q   <= 1'b0;
      ld_f3_q   <= '0;
      ld_lo_q   <= '0;
    end else begin
      state_q   <= state_d;
      wen_q     <= wen_d;
      sel_q     <= sel_d;
      data_q    <= data_d;
      instret_q <= instret_d;
      err_q     <= err_d;
      ld_rd_q   <= ld_rd_d;
      ld_rw_q   <= ld_rw_d;
      ld_f3_q   <= ld_f3_d;
      ld_lo_q   <= ld_lo_d;
    end
  end

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Scoreboard bench for wb_writeback_unit: expected writes are queued at issue
// time and a negedge monitor checks every wEn pulse against the queue.
module tb_wb_writeback_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_reg_write = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic        mem_is_load = 1'b0;
  logic [2:0]  mem_funct3 = '0;
  logic [1:0]  mem_addr_lo = '0;
  logic [31:0] mem_result = '0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;

  logic        mem_ready, wEn, wb_err;
  logic [4:0]  write_sel;
  logic [31:0] write_data;
  logic [63:0] instret;

  // Narrow-counter instance sharing the stimulus, used to observe wrap
  logic        n_ready, n_wEn, n_err;
  logic [4:0]  n_sel;
  logic [31:0] n_data;
  logic [2:0]  n_instret;

  int compared = 0;
  int mismatched = 0;

  typedef struct packed { logic [4:0] sel; logic [31:0] data; } wr_t;
  wr_t exp_q[$];

  always #5 clock = ~clock;

  wb_writeback_unit dut (
    .clock(clock), .reset(reset), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_is_load(mem_is_load),
    .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo), .mem_result(mem_result),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wEn(wEn),
    .write_sel(write_sel), .write_data(write_data), .instret(instret), .wb_err(wb_err)
  );

  wb_writeback_unit #(.INSTRET_W(3)) dut_n (
    .clock(clock), .reset(reset), .mem_valid(mem_valid), .mem_ready(n_ready),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_is_load(mem_is_load),
    .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo), .mem_result(mem_result),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wEn(n_wEn),
    .write_sel(n_sel), .write_data(n_data), .instret(n_instret), .wb_err(n_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest queued expectation
  always @(negedge clock) begin
    if (!reset && wEn) begin
      if (exp_q.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_write: got sel=%0d data=0x%0h expected none", write_sel, write_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_sel", {59'd0, write_sel}, {59'd0, e.sel});
        chk("write_data", {32'd0, write_data}, {32'd0, e.data});
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Present one instruction and hold it until accepted (bounded)
  task automatic issue(input logic ld, input logic rw, input logic [4:0] rd,
                       input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] res);
    int n;
    mem_valid = 1'b1; mem_is_load = ld; mem_reg_write = rw; mem_rd = rd;
    mem_funct3 = f3; mem_addr_lo = lo; mem_result = res;
    n = 0;
    while (!mem_ready && n < 50) begin @(posedge clock); #1; n++; end
    if (!mem_ready) begin
      compared++; mismatched++;
      $display("FAIL accept_timeout: got mem_ready=0 expected 1");
    end
    @(posedge clock); #1;
    mem_valid = 1'b0;
  endtask

  task automatic rvalid(input logic [31:0] d);
    dmem_rvalid = 1'b1; dmem_rdata = d;
    @(posedge clock); #1;
    dmem_rvalid = 1'b0;
  endtask

  task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                      input logic [31:0] raw, input logic [31:0] exp);
    exp_q.push_back('{sel: rd, data: exp});
    issue(1'b1, 1'b1, rd, f3, lo, 32'h0);
    chk("ready_in_wait", {63'd0, mem_ready}, 64'd0);
    @(posedge clock); #1;
    chk("ready_still_wait", {63'd0, mem_ready}, 64'd0);
    rvalid(raw);
    chk("ready_after_rvalid", {63'd0, mem_ready}, 64'd1);
    chk("wen_load", {63'd0, wEn}, 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    do_reset();
    chk("rst_wen", {63'd0, wEn}, 64'd0);
    chk("rst_sel", {59'd0, write_sel}, 64'd0);
    chk("rst_data", {32'd0, write_data}, 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_err", {63'd0, wb_err}, 64'd0);
    chk("rst_ready", {63'd0, mem_ready}, 64'd1);

    // Single ALU op
    exp_q.push_back('{sel: 5'd5, data: 32'h1234_5678});
    issue(1'b0, 1'b1, 5'd5, 3'b000, 2'd0, 32'h1234_5678);
    chk("alu_wen", {63'd0, wEn}, 64'd1);
    chk("alu_instret", instret, 64'd1);
    @(posedge clock); #1;
    chk("alu_wen_pulse", {63'd0, wEn}, 64'd0);

    // Loads
    load(5'd7, 3'b000, 2'd3, 32'h80FF_0000, 32'hFFFF_FF80);
    load(5'd8, 3'b100, 2'd3, 32'h80FF_0000, 32'h0000_0080);
    load(5'd9, 3'b001, 2'd2, 32'h8001_0000, 32'hFFFF_8001);
    chk("lh_aligned_err", {63'd0, wb_err}, 64'd0);
    load(5'd10, 3'b001, 2'd1, 32'h8001_0000, 32'h0000_0000);
    chk("lh_misaligned_err", {63'd0, wb_err}, 64'd1);
    load(5'd11, 3'b010, 2'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    load(5'd12, 3'b011, 2'd0, 32'hDEAD_BEEF, 32'h0000_0000);
    chk("instret_after_loads", instret, 64'd7);

    // x0 destination and non-writing op: retire without a write
    issue(1'b0, 1'b1, 5'd0, 3'b000, 2'd0, 32'hAAAA_5555);
    chk("x0_wen", {63'd0, wEn}, 64'd0);
    chk("x0_instret", instret, 64'd8);
    issue(1'b0, 1'b0, 5'd3, 3'b000, 2'd0, 32'h0000_0033);
    chk("norw_wen", {63'd0, wEn}, 64'd0);
    chk("norw_instret", instret, 64'd9);

    // Four back-to-back ALU ops from reset
    do_reset();
    chk("rst2_err", {63'd0, wb_err}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1'b1; mem_is_load = 1'b0; mem_reg_write = 1'b1;
      mem_rd = 5'(i + 1); mem_result = 32'h100 + 32'(i);
      exp_q.push_back('{sel: 5'(i + 1), data: 32'h100 + 32'(i)});
      @(posedge clock); #1;
      chk("b2b_wen", {63'd0, wEn}, 64'd1);
      chk("b2b_instret", instret, 64'(i + 1));
    end
    mem_valid = 1'b0;
    @(posedge clock); #1;
    chk("b2b_instret_final", instret, 64'd4);
    chk("b2b_wen_idle", {63'd0, wEn}, 64'd0);

    // Reset abandons an outstanding load; later rvalid is an IDLE error
    issue(1'b1, 1'b1, 5'd9, 3'b010, 2'd0, 32'h0);
    do_reset();
    rvalid(32'h1111_2222);
    chk("abandon_wen", {63'd0, wEn}, 64'd0);
    chk("abandon_ready", {63'd0, mem_ready}, 64'd1);
    chk("abandon_instret", instret, 64'd0);
    chk("abandon_err", {63'd0, wb_err}, 64'd1);

    // Counter wrap on the 3-bit instance after 8 retirements
    do_reset();
    for (int i = 0; i < 8; i++) begin
      mem_valid = 1'b1; mem_is_load = 1'b0; mem_reg_write = 1'b1;
      mem_rd = 5'd20; mem_result = 32'(i);
      exp_q.push_back('{sel: 5'd20, data: 32'(i)});
      @(posedge clock); #1;
    end
    mem_valid = 1'b0;
    chk("wrap_narrow_instret", {61'd0, n_instret}, 64'd0);
    chk("wrap_narrow_err", {63'd0, n_err}, 64'd0);
    chk("wrap_wide_instret", instret, 64'd8);

    repeat (3) @(posedge clock); #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
